// File: rtl/wb_commit_unit_pkg.sv
// Shared types and helpers for the write-back commit unit: entry struct,
// width constants and the destination one-hot decode used by the pending mask.
package wb_commit_unit_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;
   localparam int NREG   = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] dest;
      logic [DATA_W-1:0] value;
   } wb_entry_t;

   function automatic logic [NREG-1:0] dest_onehot(input logic [ADDR_W-1:0] dest);
      logic [NREG-1:0] hot;
      hot       = '0;
      hot[dest] = 1'b1;
      return hot;
   endfunction

endpackage

// File: rtl/wb_commit_unit_fifo.sv
// In-order circular buffer for write-back results: two ordered push ports
// (push1 is younger and only used together with push0), one pop port, occupancy count.
module wb_commit_fifo
   import wb_commit_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push0,
   input  wb_entry_t              push0_entry,
   input  logic                   push1,
   input  wb_entry_t              push1_entry,
   input  logic                   pop,
   output wb_entry_t              head_entry,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   wb_entry_t        slots [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_p1;

   // DEPTH is a power of two, so pointer arithmetic wraps for free.
   assign wr_ptr_p1  = wr_ptr + 1'b1;
   assign head_entry = slots[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         wr_ptr <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
         count  <= count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
      end
   end

   // NOTE: storage is deliberately not reset; occupancy lives in the pointers
   // and count, so stale slot contents are never observed.
   always_ff @(posedge clk) begin
      if (push0) slots[wr_ptr]    <= push0_entry;
      if (push1) slots[wr_ptr_p1] <= push1_entry;
   end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back commit unit: merges load and ALU results into one in-order register write per cycle.
// Optional macro WB_PENDING_MASK_EN builds the registered pending-write mask.
module wb_commit_unit
   import wb_commit_unit_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mem_valid,
   input  logic [ADDR_W-1:0]      mem_dest,
   input  logic [DATA_W-1:0]      mem_data,
   input  logic                   alu_valid,
   input  logic [ADDR_W-1:0]      alu_dest,
   input  logic [DATA_W-1:0]      alu_result,
   output logic                   in_ready,
   output logic                   wb_en,
   output logic [ADDR_W-1:0]      wb_dest,
   output logic [DATA_W-1:0]      wb_value,
   output logic [NREG-1:0]        pending_mask,
   output logic [$clog2(DEPTH):0] buf_count
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic      mem_acc;
   logic      alu_acc;
   wb_entry_t mem_entry;
   wb_entry_t alu_entry;
   wb_entry_t head_entry;
   wb_entry_t out_entry;
   wb_entry_t push0_entry;
   wb_entry_t push1_entry;
   logic      out_load;
   logic      pop;
   logic      push0;
   logic      push1;

   // Headroom for two pushes against one pop keeps the buffer from overflowing.
   assign in_ready  = (buf_count <= CNT_W'(DEPTH - 2));
   assign mem_acc   = mem_valid & in_ready;
   assign alu_acc   = alu_valid & in_ready;
   assign mem_entry = '{dest: mem_dest, value: mem_data};
   assign alu_entry = '{dest: alu_dest, value: alu_result};

   // Candidate order is buffer head, then load, then ALU; oldest goes to the port.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      out_load    = 1'b0;
      out_entry   = head_entry;
      pop         = 1'b0;
      push0       = 1'b0;
      push0_entry = mem_entry;
      push1       = 1'b0;
      push1_entry = alu_entry;
      if (buf_count != '0) begin
         out_load = 1'b1;
         pop      = 1'b1;
         if (mem_acc) begin
            push0 = 1'b1;
            push1 = alu_acc;
         end else if (alu_acc) begin
            push0       = 1'b1;
            push0_entry = alu_entry;
         end
      end else if (mem_acc) begin
         out_load    = 1'b1;
         out_entry   = mem_entry;
         push0       = alu_acc;
         push0_entry = alu_entry;
      end else if (alu_acc) begin
         out_load  = 1'b1;
         out_entry = alu_entry;
      end
   end

   wb_commit_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push0       (push0),
      .push0_entry (push0_entry),
      .push1       (push1),
      .push1_entry (push1_entry),
      .pop         (pop),
      .head_entry  (head_entry),
      .count       (buf_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_en    <= 1'b0;
         wb_dest  <= '0;
         wb_value <= '0;
      end else begin
         wb_en <= out_load;
         if (out_load) begin
            wb_dest  <= out_entry.dest;
            wb_value <= out_entry.value;
         end
      end
   end

`ifdef WB_PENDING_MASK_EN
   // Per-register count of writes accepted but not yet retired from the port;
   // a register is pending while its count is non-zero.
   localparam int PC_W = $clog2(DEPTH + 2);

   logic [PC_W-1:0] pend_cnt [NREG];
   logic [PC_W-1:0] pend_nxt [NREG];
   logic [NREG-1:0] mem_hot;
   logic [NREG-1:0] alu_hot;
   logic [NREG-1:0] out_hot;
   logic [NREG-1:0] mask_q;

   assign mem_hot = mem_acc ? dest_onehot(mem_dest) : '0;
   assign alu_hot = alu_acc ? dest_onehot(alu_dest) : '0;
   assign out_hot = wb_en   ? dest_onehot(wb_dest)  : '0;

   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         pend_nxt[r] = pend_cnt[r] + PC_W'(mem_hot[r]) + PC_W'(alu_hot[r]) - PC_W'(out_hot[r]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) pend_cnt[r] <= '0;
         mask_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            pend_cnt[r] <= pend_nxt[r];
            mask_q[r]   <= (pend_nxt[r] != '0);
         end
      end
   end

   assign pending_mask = mask_q;
`else
   assign pending_mask = '0;
`endif

endmodule
